mlp_input_feeder: RTL and testbench
===================================

MLP_INPUT_FEEDER -- requirements
Module: mlp_input_feeder

Interface
REQ-001: The block SHALL have parameter IN_DIM, default 64, giving the number of input features per vector.
REQ-002: The block SHALL have parameter DATA_W, default 8, giving the width of each feature in bits.
REQ-003: The block SHALL have parameter TIMEOUT, default 4096, giving the maximum number of cycles to wait for done.
REQ-004: The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005: The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-006: The block SHALL have port s_valid, input, 1 bit, indicating that a feature byte is offered.
REQ-007: The block SHALL have port s_data, input, DATA_W bits, carrying the feature byte.
REQ-008: The block SHALL have port s_ready, output, 1 bit, indicating that the block accepts s_data this cycle.
REQ-009: The block SHALL have port abort, input, 1 bit, which discards a partially filled vector.
REQ-010: The block SHALL have port bus_out, output, DATA_W*IN_DIM bits, carrying the packed vector to the MLP core's bus_in.
REQ-011: The block SHALL have port start, output, 1 bit, a single-cycle start pulse to the MLP core.
REQ-012: The block SHALL have port done, input, 1 bit, the MLP core's completion flag (output layer finished); it may be level or pulse.
REQ-013: The block SHALL have port class_in, input, 4 bits, the MLP core's class_idx.
REQ-014: The block SHALL have port r_valid, output, 1 bit, indicating that a result is held.
REQ-015: The block SHALL have port r_class, output, 4 bits, the captured class index.
REQ-016: The block SHALL have port r_err, output, 1 bit, set when the result came from a timeout.
REQ-017: The block SHALL have port r_ready, input, 1 bit, the result consumer's acceptance.
REQ-018: The block SHALL have port busy, output, 1 bit, high in states START, WAIT and RESULT.

Function
REQ-019: The block SHALL implement the FSM states FILL, START, WAIT and RESULT.
REQ-020: In FILL, s_ready SHALL be 1; in every other state, and while rst is high, s_ready SHALL be 0.
REQ-021: A byte SHALL be accepted on a rising edge where s_valid and s_ready are both 1; the k-th accepted byte (k=0..IN_DIM-1) SHALL be written to bus_out[DATA_W*(IN_DIM-1-k) +: DATA_W], so the first byte is the MSB.
REQ-022: A byte counter (7 bits at IN_DIM=64) SHALL increment per accepted byte; acceptance of byte IN_DIM-1 SHALL move the FSM to START and clear the counter.
REQ-023: In FILL, abort=1 SHALL clear the counter and take priority over a same-cycle byte, which is dropped; bus_out contents are not cleared; abort SHALL be ignored in all other states.
REQ-024: START SHALL last exactly one cycle with start=1, then go to WAIT; start SHALL be 0 in all other cycles.
REQ-025: bus_out SHALL change only on byte acceptance and SHALL be stable from the cycle start is high until the FSM returns to FILL.
REQ-026: In WAIT, done=1 SHALL capture class_in into r_class, set r_err=0 and r_valid=1, and move to RESULT on the same edge.
REQ-027: The WAIT cycle counter SHALL start at 0 on entry; if done has not been seen after TIMEOUT cycles in WAIT, the block SHALL go to RESULT with r_valid=1, r_err=1 and r_class=4'hF.
REQ-028: done SHALL be ignored outside WAIT, including in the START cycle.
REQ-029: In RESULT, r_valid, r_class and r_err SHALL hold until r_ready=1; the handshake edge SHALL clear r_valid and return the FSM to FILL with counter 0.
REQ-030: Latency: with the last byte accepted at edge N, start SHALL be high in cycle N..N+1 and the FSM SHALL be in WAIT from edge N+1; with done sampled at edge M, r_valid SHALL be high from edge M.
REQ-031: Throughput: bytes SHALL be accepted back-to-back at one per cycle.

Reset
REQ-032: While rst is sampled high, the block SHALL enter FILL with counter 0, bus_out=0, start=0, r_valid=0, r_class=0, r_err=0 and the WAIT counter at 0.
REQ-033: Reset asserted in any state, including mid-fill or mid-WAIT, SHALL abandon the operation with no start pulse and no result.
REQ-034: s_ready SHALL be 1 in the first cycle after rst is released.

Verification
REQ-035: Stream 64 bytes 0x10,0x22,0xF3,... back-to-back -> bus_out[511:504]=0x10, bus_out[7:0]=last byte, exactly one start pulse one cycle after the last accept, busy=1.
REQ-036: Drive done=1 with class_in=7 four cycles after start, then hold r_ready=0 for 3 cycles -> r_valid=1, r_class=7, r_err=0 held stable; r_ready=1 -> r_valid=0, s_ready=1 next cycle.
REQ-037: Send 30 bytes, then abort=1 concurrent with s_valid=1 -> counter is 0 and the byte is dropped; 64 further bytes of 0x7F -> bus_out all 0x7F and one start pulse.
REQ-038: Set TIMEOUT=16 and never assert done -> r_valid=1, r_err=1, r_class=0xF after exactly 16 cycles in WAIT.
REQ-039: Drive done=1 during FILL and during the START cycle -> ignored; pulse rst mid-fill after 40 bytes -> bus_out=0, no start, and the next 64 bytes produce a correct vector.
REQ-040: Toggle s_valid randomly (~50%) over 64 bytes -> correct packing order, and s_ready=0 while busy for every byte offered then.

Source files
------------

// File: rtl/mlp_input_feeder.sv
// Collects a stream of feature bytes into a packed vector, kicks the MLP core with a
// one-cycle start pulse, then captures its class result (or a timeout) for a consumer.
module mlp_input_feeder #(
  parameter int unsigned IN_DIM  = 64,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     s_ready,
  input  logic                     abort,
  output logic [DATA_W*IN_DIM-1:0] bus_out,
  output logic                     start,
  input  logic                     done,
  input  logic [3:0]               class_in,
  output logic                     r_valid,
  output logic [3:0]               r_class,
  output logic                     r_err,
  input  logic                     r_ready,
  output logic                     busy
);

  localparam int unsigned BusW  = DATA_W * IN_DIM;
  localparam int unsigned CntW  = $clog2(IN_DIM + 1);
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0]  LastIdx  = CntW'(IN_DIM - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StFill,
    StStart,
    StWait,
    StResult
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [BusW-1:0]   bus_q, bus_d;
  logic              r_valid_q, r_valid_d;
  logic [3:0]        r_class_q, r_class_d;
  logic              r_err_q, r_err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_d     = bus_q;
    wait_d    = '0;
    r_valid_d = r_valid_q;
    r_class_d = r_class_q;
    r_err_d   = r_err_q;

    unique case (state_q)
      StFill: begin
        // Abort wins over a same-cycle byte; the partial vector contents stay put.
        if (abort) begin
          cnt_d = '0;
        end else if (s_valid) begin
          // First accepted byte lands in the most significant slot.
          for (int unsigned k = 0; k < IN_DIM; k++) begin
            if (cnt_q == CntW'(k)) begin
              bus_d[DATA_W*(IN_DIM-1-k) +: DATA_W] = s_data;
            end
          end
          if (cnt_q == LastIdx) begin
            cnt_d   = '0;
            state_d = StStart;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StStart: begin
        state_d = StWait;
      end

      StWait: begin
        if (done) begin
          r_valid_d = 1'b1;
          r_class_d = class_in;
          r_err_d   = 1'b0;
          state_d   = StResult;
        end else if (wait_q == WaitLast) begin
          r_valid_d = 1'b1;
          r_class_d = 4'hF;
          r_err_d   = 1'b1;
          state_d   = StResult;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      StResult: begin
        if (r_ready) begin
          r_valid_d = 1'b0;
          cnt_d     = '0;
          state_d   = StFill;
        end
      end

      default: begin
        state_d = StFill;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFill;
      cnt_q     <= '0;
      wait_q    <= '0;
      bus_q     <= '0;
      r_valid_q <= 1'b0;
      r_class_q <= 4'h0;
      r_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      bus_q     <= bus_d;
      r_valid_q <= r_valid_d;
      r_class_q <= r_class_d;
      r_err_q   <= r_err_d;
    end
  end

  // Gated by rst so a reset landing in FILL or START never shows ready or a start pulse.
  assign s_ready = (state_q == StFill) && !rst;
  assign start   = (state_q == StStart) && !rst;
  assign busy    = (state_q != StFill);
  assign bus_out = bus_q;
  assign r_valid = r_valid_q;
  assign r_class = r_class_q;
  assign r_err   = r_err_q;

endmodule

// File: tb/tb_mlp_input_feeder.sv
// Self-checking bench for mlp_input_feeder: table-driven vectors with random bytes,
// plus hand sequences for abort, reset mid-fill and reset mid-wait.
module tb_mlp_input_feeder;

  localparam int unsigned IN_DIM  = 64;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned BW      = IN_DIM * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              abort;
  logic [BW-1:0]     bus_out;
  logic              start;
  logic              done;
  logic [3:0]        class_in;
  logic              r_valid;
  logic [3:0]        r_class;
  logic              r_err;
  logic              r_ready;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int viol = 0;

  logic [DATA_W-1:0] sent [IN_DIM];

  typedef struct {
    int         kind;       // 0 fixed pattern, 1 random, 2 all 0x7F, 3 all 0xFF
    bit         gappy;      // random s_valid gaps between bytes
    bit         done_fill;  // hold done high while filling
    bit         done_start; // raise done during the start cycle
    int         delay;      // cycles after start that done is seen; <0 means never
    logic [3:0] cls;
    logic [3:0] exp_class;
    logic       exp_err;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  mlp_input_feeder #(
    .IN_DIM (IN_DIM),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .abort   (abort),
    .bus_out (bus_out),
    .start   (start),
    .done    (done),
    .class_in(class_in),
    .r_valid (r_valid),
    .r_class (r_class),
    .r_err   (r_err),
    .r_ready (r_ready),
    .busy    (busy)
  );

  always @(negedge clk) begin
    if (start) n_start <= n_start + 1;
    if (s_valid && busy && s_ready) viol <= viol + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] gen(input int kind, input int k);
    case (kind)
      0: begin
        case (k)
          0:       return 8'h10;
          1:       return 8'h22;
          2:       return 8'hF3;
          default: return DATA_W'(k * 37 + 5);
        endcase
      end
      2:       return 8'h7F;
      3:       return 8'hFF;
      default: return DATA_W'($urandom);
    endcase
  endfunction

  // Shift each byte in from the right: the first byte ends up at the top.
  function automatic logic [BW-1:0] pack();
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < IN_DIM; k++) v = {v[BW-DATA_W-1:0], sent[k]};
    return v;
  endfunction

  task automatic offer(input logic [DATA_W-1:0] b);
    bit acc;
    int guard;
    s_valid = 1'b1;
    s_data  = b;
    acc     = 1'b0;
    guard   = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = s_ready;
      tick();
      guard++;
    end
    s_valid = 1'b0;
    chk("accept_one_cycle", guard, 1);
  endtask

  task automatic stream(input int kind, input bit gappy, input bit done_fill);
    for (int k = 0; k < IN_DIM; k++) begin
      sent[k] = gen(kind, k);
      if (gappy && $urandom_range(1, 0) == 1) begin
        s_valid = 1'b0;
        s_data  = DATA_W'($urandom);
        repeat ($urandom_range(2, 1)) tick();
      end
      if (done_fill) begin
        done     = (k != IN_DIM - 1);
        class_in = 4'h9;
      end
      offer(sent[k]);
    end
    done = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int            s0;
    logic [BW-1:0] exp_bus;
    s0 = n_start;
    stream(v.kind, v.gappy, v.done_fill);
    exp_bus = pack();
    if (v.done_start) begin
      done     = 1'b1;
      class_in = 4'h3;
    end
    @(negedge clk);
    chk("start_pulse", start, 1);
    chk("busy_start", busy, 1);
    chk("s_ready_start", s_ready, 0);
    chk("bus_vec", bus_out, exp_bus);
    chk("bus_msb", bus_out[BW-1 -: DATA_W], sent[0]);
    chk("bus_lsb", bus_out[DATA_W-1:0], sent[IN_DIM-1]);
    tick();
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = DATA_W'($urandom);
    if (v.delay < 0) begin
      repeat (TIMEOUT - 1) tick();
      @(negedge clk);
      chk("r_valid_before_timeout", r_valid, 0);
      chk("start_only_once", start, 0);
      tick();
      @(negedge clk);
    end else begin
      if (v.delay > 1) repeat (v.delay - 1) tick();
      done     = 1'b1;
      class_in = v.cls;
      @(negedge clk);
      chk("r_valid_before_done", r_valid, 0);
      tick();
      done     = 1'b0;
      class_in = 4'($urandom);
      @(negedge clk);
    end
    chk("r_valid_set", r_valid, 1);
    chk("r_class", r_class, v.exp_class);
    chk("r_err", r_err, v.exp_err);
    for (int i = 0; i < 3; i++) begin
      tick();
      s_data = DATA_W'($urandom);
      @(negedge clk);
      chk("hold_valid", r_valid, 1);
      chk("hold_class", r_class, v.exp_class);
      chk("hold_err", r_err, v.exp_err);
      chk("hold_bus", bus_out, exp_bus);
      chk("hold_busy", busy, 1);
    end
    tick();
    s_valid = 1'b0;
    r_ready = 1'b1;
    @(negedge clk);
    chk("valid_on_handshake", r_valid, 1);
    tick();
    r_ready = 1'b0;
    @(negedge clk);
    chk("r_valid_cleared", r_valid, 0);
    chk("s_ready_after", s_ready, 1);
    chk("busy_after", busy, 0);
    chk("one_start", n_start - s0, 1);
    chk("ready_while_busy", viol, 0);
    tick();
  endtask

  initial begin
    vec_t extra;
    int   s0;

    tbl[0] = '{0, 1'b0, 1'b0, 1'b0,  4, 4'd7,  4'd7,  1'b0};
    tbl[1] = '{1, 1'b1, 1'b0, 1'b0, 16, 4'd2,  4'd2,  1'b0};
    tbl[2] = '{1, 1'b0, 1'b0, 1'b0, -1, 4'd0,  4'hF,  1'b1};
    tbl[3] = '{1, 1'b1, 1'b1, 1'b1,  6, 4'd5,  4'd5,  1'b0};
    tbl[4] = '{3, 1'b0, 1'b0, 1'b0,  1, 4'd0,  4'd0,  1'b0};
    tbl[5] = '{1, 1'b1, 1'b0, 1'b0, 15, 4'hF,  4'hF,  1'b0};

    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    abort    = 1'b0;
    done     = 1'b0;
    class_in = 4'h0;
    r_ready  = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("s_ready_in_rst", s_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_bus", bus_out, 0);
    chk("rst_start", start, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_class", r_class, 0);
    chk("rst_r_err", r_err, 0);
    chk("rst_busy", busy, 0);
    tick();

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Abort with a concurrent byte after 30 bytes.
    for (int k = 0; k < 30; k++) offer(DATA_W'($urandom));
    s_valid = 1'b1;
    s_data  = 8'hAA;
    abort   = 1'b1;
    @(negedge clk);
    chk("s_ready_abort", s_ready, 1);
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    extra = '{2, 1'b0, 1'b0, 1'b0, 2, 4'hA, 4'hA, 1'b0};
    run_vec(extra);

    // Reset mid-fill after 40 bytes.
    s0 = n_start;
    for (int k = 0; k < 40; k++) offer(DATA_W'($urandom));
    rst = 1'b1;
    @(negedge clk);
    chk("s_ready_rst_fill", s_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_fill_bus", bus_out, 0);
    chk("rst_fill_s_ready", s_ready, 1);
    chk("rst_fill_busy", busy, 0);
    repeat (3) tick();
    chk("rst_fill_no_start", n_start - s0, 0);
    extra = '{1, 1'b0, 1'b0, 1'b0, 3, 4'hC, 4'hC, 1'b0};
    run_vec(extra);

    // Reset mid-wait abandons the result.
    s0 = n_start;
    stream(1, 1'b0, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_r_valid", r_valid, 0);
    chk("rst_wait_s_ready", s_ready, 1);
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_bus", bus_out, 0);
    repeat (TIMEOUT + 4) tick();
    @(negedge clk);
    chk("rst_wait_no_result", r_valid, 0);
    chk("rst_wait_one_start", n_start - s0, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
